ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Registered execute stage of the 32-bit pipelined CPU. Sits directly downstream of operand selection (ID/EX) and feeds the memory stage.
- Computes the ALU operation, including signed set-less-than. Registers the result with a ready/valid handshake and a one-entry skid buffer, so a memory-stage stall never drops an instruction.
- Produces zero and signed-overflow flags used by the branch and exception logic.

Parameters:
- WIDTH, 32, datapath width in bits.
- TAGW, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous kill of all held instructions (branch or exception redirect).
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_op  input  3  ALU control code.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; in_b[4:0] is the shift amount for shifts.
- in_rd  input  TAGW  destination register.
- in_wb  input  1  instruction writes a register.
- out_valid  output  1  result register holds a valid instruction.
- out_ready  input  1  downstream consumes the result this cycle.
- out_res  output  WIDTH  ALU result.
- out_zero  output  1  out_res == 0.
- out_ovf  output  1  signed overflow on ADD/SUB.
- out_rd  output  TAGW  destination tag.
- out_wb  output  1  register write enable.

Behaviour:
- Reset and ports:
  - clk and rst_n form the single clock and reset. Reset is synchronous and active-low.
  - Reset state: out_valid=0, skid empty, out_res=0, out_zero=1, out_ovf=0, out_rd=0, out_wb=0, in_ready=1.
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 100 NOR, 011 XOR, 101 SRL (logical right shift by in_b[4:0]).
  - Undefined codes produce result 0, out_ovf=0.
- SLT:
  - Result is 1 when A<B as two's-complement, otherwise 0; upper bits are 0.
  - Operands with differing signs are decided by the sign bit alone, never by an unsigned compare.
- Overflow:
  - ADD: set when A and B have the same sign and the sum's sign differs.
  - SUB: set when A and B have differing signs and the result's sign differs from A.
  - All other ops: 0.
  - Results wrap modulo 2^WIDTH.
- Register-write gating: out_wb is forced to 0 when in_rd==0 (the zero register is never written).
- Handshake:
  - Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
  - in_ready is registered and equals "skid empty".
- Data movement on a clock edge (no flush):
  - Output register empty, or output transfer this cycle:
    - Skid full: skid moves into the output register and skid empties.
    - Else, input transfer this cycle: the computed input is loaded into the output register.
    - Else: out_valid becomes 0.
  - Output register full and stalled (out_valid && !out_ready), input transfer this cycle: the computed input is written into the skid and in_ready drops next cycle.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid when not stalled.
  - Sustained throughput is one instruction per cycle.
- Ordering: instructions always leave in acceptance order; the skid entry always precedes any later input.
- Flush:
  - On the next edge, out_valid=0 and skid empty, so in_ready=1.
  - An input transferred in the same cycle as flush is discarded.
  - An output transfer in the flush cycle still counts as consumed downstream.
  - Data fields keep their old values, but out_wb is cleared.
- Priority: reset > flush > normal operation.
- Stability: while out_valid && !out_ready, all out_* fields hold stable.

Test Plan:
- SLT sign cases: A=0xFFFFFFFF, B=0x00000001 -> out_res=1. A=0x00000001, B=0xFFFFFFFF -> 0. A=0x80000000, B=0x7FFFFFFF -> 1. A=B=0x12345678 -> 0 with out_zero=1.
- Overflow: ADD 0x7FFFFFFF+1 -> out_res=0x80000000, out_ovf=1. SUB 0x80000000-1 -> 0x7FFFFFFF, out_ovf=1. ADD 0xFFFFFFFF+1 -> 0, out_zero=1, out_ovf=0.
- Back-pressure: stream 4 ADDs with out_ready held 0 from cycle 1 -> in_ready drops after the 2nd transfer. Raise out_ready -> results emerge in order with no loss or duplication.
- Flush mid-stall: output and skid both full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the 3 instructions appear.
- rd=0 gating plus SRL: op 101, A=0x80000000, B=4, in_rd=0, in_wb=1 -> out_res=0x08000000, out_wb=0.
- Reset mid-operation: rst_n low for one cycle with both entries full -> all outputs at reset values on the next edge, in_ready=1.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute stage: combinational ALU feeding a registered output slot backed by
// a one-entry skid buffer, so a stalled memory stage never loses an instruction.
//
// Handshake: a transfer on either side happens only on a rising edge where
// valid && ready are both high. in_ready is a register (it is "skid empty"),
// never a combinational function of out_ready. While out_valid is high and
// out_ready is low, every out_* field holds its value.
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_rd,
    input  logic             in_wb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [TAGW-1:0]  out_rd,
    output logic             out_wb
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // One instruction's worth of stage output.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        logic [TAGW-1:0]  rd;
        logic             wb;
    } payload_t;

    localparam payload_t RESET_PL = '{res: '0, zero: 1'b1, ovf: 1'b0, rd: '0, wb: 1'b0};

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             a_sign;
    logic             b_sign;
    logic             slt_lt;
    payload_t         in_pl;

    // Compute the result and signed-overflow flag for the incoming instruction.
    always_comb begin
        sum_w   = in_a + in_b;
        diff_w  = in_a - in_b;
        a_sign  = in_a[WIDTH-1];
        b_sign  = in_b[WIDTH-1];
        alu_res = '0;
        alu_ovf = 1'b0;

        // Differing signs: the negative operand is smaller. Same signs: the
        // subtraction cannot overflow, so the sign of A-B decides.
        if (a_sign != b_sign) begin
            slt_lt = a_sign;
        end else begin
            slt_lt = diff_w[WIDTH-1];
        end

        case (in_op)
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_XOR: alu_res = in_a ^ in_b;
            OP_NOR: alu_res = ~(in_a | in_b);
            OP_ADD: begin
                alu_res = sum_w;
                alu_ovf = (a_sign == b_sign) && (sum_w[WIDTH-1] != a_sign);
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_ovf = (a_sign != b_sign) && (diff_w[WIDTH-1] != a_sign);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_SRL: alu_res = in_a >> in_b[4:0];
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Package the computed instruction; the zero register is never written.
    always_comb begin
        in_pl      = RESET_PL;
        in_pl.res  = alu_res;
        in_pl.zero = (alu_res == '0);
        in_pl.ovf  = alu_ovf;
        in_pl.rd   = in_rd;
        in_pl.wb   = in_wb && (in_rd != '0);
    end

    // ------------------------------------------------------------------
    // Output register and skid buffer
    // ------------------------------------------------------------------
    logic     out_valid_q, out_valid_d;
    payload_t out_q, out_d;
    logic     skid_valid_q, skid_valid_d;
    payload_t skid_q, skid_d;
    logic     in_fire;
    logic     out_open;

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    // Output slot can take new contents: empty, or being consumed this edge.
    assign out_open = !out_valid_q || out_ready;

    // Next-state for the output slot and skid entry; skid always drains first
    // so instructions leave in acceptance order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (flush) begin
            // Kill everything held; data fields stay but the write enable drops.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            out_d.wb     = 1'b0;
        end else if (out_open) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = in_pl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the new instruction in the skid entry.
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= RESET_PL;
            skid_valid_q <= 1'b0;
            skid_q       <= RESET_PL;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_q.res;
    assign out_zero  = out_q.zero;
    assign out_ovf   = out_q.ovf;
    assign out_rd    = out_q.rd;
    assign out_wb    = out_q.wb;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed ALU vectors with literal expectations,
// back-pressure, flush and mid-operation reset scenarios, all continuously
// checked against a queue-level model of the stage.
module tb_ex_alu_stage;

    localparam int W = 32;
    localparam int T = 5;
    localparam int PW = W + 1 + 1 + T + 1;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;
    localparam logic [PW-1:0] RESET_PL = {32'h0, 1'b1, 1'b0, 5'd0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = 3'b000;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [T-1:0] in_rd = '0;
    logic         in_wb = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_ovf;
    logic [T-1:0] out_rd;
    logic         out_wb;

    ex_alu_stage #(.WIDTH(W), .TAGW(T)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_rd(out_rd), .out_wb(out_wb)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level ALU: plain signed arithmetic, packed as {res,zero,ovf,rd,wb}.
    function automatic logic [PW-1:0] model_alu(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [T-1:0] rd,
                                                input logic wb);
        longint sa, sb, wide;
        logic [W-1:0] res;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        wide = 0;
        res = '0;
        ovf = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b011: res = a ^ b;
            3'b100: res = ~(a | b);
            3'b010: begin wide = sa + sb; res = wide[31:0]; ovf = (wide > SMAX) || (wide < SMIN); end
            3'b110: begin wide = sa - sb; res = wide[31:0]; ovf = (wide > SMAX) || (wide < SMIN); end
            3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
            3'b101: res = a >> b[4:0];
            default: res = '0;
        endcase
        return {res, (res == 32'd0), ovf, rd, (wb && (rd != 5'd0))};
    endfunction

    // Stage modelled as an in-order queue of at most two held instructions;
    // "shown" is what the output fields display (last head, even once empty).
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] shown = RESET_PL;

    always @(posedge clk) begin
        bit take_in;
        if (!rst_n) begin
            exp_q.delete();
            shown = RESET_PL;
        end else if (flush) begin
            exp_q.delete();
            shown[0] = 1'b0;
        end else begin
            take_in = in_valid && (exp_q.size() < 2);
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (take_in) exp_q.push_back(model_alu(in_op, in_a, in_b, in_rd, in_wb));
            if (exp_q.size() > 0) shown = exp_q[0];
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("out_fields", 64'({out_res, out_zero, out_ovf, out_rd, out_wb}), 64'(shown));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] rd, input logic wb);
        bit acc;
        acc = 1'b0;
        in_op = op; in_a = a; in_b = b; in_rd = rd; in_wb = wb;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = (exp_q.size() < 2);
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) chk("issue_accept", 64'(acc), 64'd1);
    endtask

    task automatic expect_lit(input string name, input logic [W-1:0] res, input logic zero,
                              input logic ovf, input logic wb);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_res"}, 64'(out_res), 64'(res));
        chk({name, "_zero"}, 64'(out_zero), 64'(zero));
        chk({name, "_ovf"}, 64'(out_ovf), 64'(ovf));
        chk({name, "_wb"}, 64'(out_wb), 64'(wb));
    endtask

    task automatic expect_reset_state(input string name);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_res"}, 64'(out_res), 64'd0);
        chk({name, "_zero"}, 64'(out_zero), 64'd1);
        chk({name, "_ovf"}, 64'(out_ovf), 64'd0);
        chk({name, "_rd"}, 64'(out_rd), 64'd0);
        chk({name, "_wb"}, 64'(out_wb), 64'd0);
    endtask

    // Directed vectors with hand-computed results.
    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] rd;
        logic         wb;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ewb;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [T-1:0] rd, input logic wb,
                           input logic [W-1:0] res, input logic zero, input logic ovf,
                           input logic ewb);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.rd = rd; v.wb = wb;
        v.res = res; v.zero = zero; v.ovf = ovf; v.ewb = ewb;
        vecs.push_back(v);
    endtask

    logic [15:0] ready_pat = 16'b1011_0010_1100_1110;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, got no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        add_vec("slt_neg_pos", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
        add_vec("slt_pos_neg", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec("slt_min_max", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd3, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
        add_vec("slt_max_min", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd4, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec("slt_equal",   3'b111, 32'h1234_5678, 32'h1234_5678, 5'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec("add_ovf",     3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd6, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        add_vec("sub_ovf",     3'b110, 32'h8000_0000, 32'h0000_0001, 5'd7, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        add_vec("add_wrap",    3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec("srl_rd0",     3'b101, 32'h8000_0000, 32'h0000_0004, 5'd0, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        add_vec("srl_amt5",    3'b101, 32'hFFFF_FFFF, 32'h0000_0025, 5'd9, 1'b1, 32'h07FF_FFFF, 1'b0, 1'b0, 1'b1);
        add_vec("and",         3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 1'b1);
        add_vec("or",          3'b001, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd11, 1'b0, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b0);
        add_vec("xor",         3'b011, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd12, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1);
        add_vec("nor",         3'b100, 32'h0000_0000, 32'h0000_0000, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        add_vec("sub_neg",     3'b110, 32'h0000_0005, 32'h0000_0007, 5'd14, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        add_vec("sub_ovf2",    3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        expect_reset_state("reset");

        // Directed ALU vectors, one at a time
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wb);
            expect_lit(vecs[i].name, vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].ewb);
            chk({vecs[i].name, "_rd"}, 64'(out_rd), 64'(vecs[i].rd));
        end

        // Back-to-back stream, one instruction per cycle
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wb);
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: 4 ADDs with out_ready low from the first one
        out_ready = 1'b0;
        issue(3'b010, 32'd1, 32'd1, 5'd1, 1'b1);
        issue(3'b010, 32'd2, 32'd2, 5'd2, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head_res", 64'(out_res), 64'd2);
        in_op = 3'b010; in_a = 32'd3; in_b = 32'd3; in_rd = 5'd3; in_wb = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_res", 64'(out_res), 64'd2);
            chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_second_res", 64'(out_res), 64'd4);
        issue(3'b010, 32'd3, 32'd3, 5'd3, 1'b1);
        @(negedge clk);
        chk("bp_third_res", 64'(out_res), 64'd6);
        issue(3'b010, 32'd4, 32'd4, 5'd4, 1'b1);
        @(negedge clk);
        chk("bp_fourth_res", 64'(out_res), 64'd8);
        repeat (2) @(posedge clk);
        #1;

        // Streaming against a fixed out_ready pattern
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    out_ready = ready_pat[i % 16];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            begin
                foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wb);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Flush mid-stall with both entries full and a third instruction offered
        out_ready = 1'b0;
        issue(3'b010, 32'd10, 32'd1, 5'd7, 1'b1);
        issue(3'b010, 32'd20, 32'd1, 5'd8, 1'b1);
        in_op = 3'b010; in_a = 32'd30; in_b = 32'd1; in_rd = 5'd9; in_wb = 1'b1;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_wb_cleared", 64'(out_wb), 64'd0);
        chk("flush_res_held", 64'(out_res), 64'd11);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_nothing_emerges", 64'(out_valid), 64'd0);
        end

        // Flush while an input transfers into an empty stage
        @(posedge clk); #1;
        in_op = 3'b001; in_a = 32'h5; in_b = 32'h2; in_rd = 5'd3; in_wb = 1'b1;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_input_dropped", 64'(out_valid), 64'd0);

        // Reset mid-operation with both entries full
        out_ready = 1'b0;
        issue(3'b011, 32'hFF, 32'h0F, 5'd4, 1'b1);
        issue(3'b000, 32'hFF, 32'h0F, 5'd5, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_reset_state("midreset");

        // Stage works again after reset
        issue(3'b010, 32'd40, 32'd2, 5'd6, 1'b1);
        expect_lit("post_reset_add", 32'd42, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
